cpu_controller: RTL and testbench

Parametrised instruction-sequencing FSM for the simple RISC CPU. It is the successor to the lab-7 instruction state machine. It drives the register-file/datapath controls, program-counter controls and memory interface from opcode/op/cond fields and the status flags. New over the previous generation: memory wait-state handshake (mem_ready) with a programmable timeout, full LDR/STR sequencing, conditional branches, and a sticky error state.

---
 rtl/cpu_controller.sv | 158 +++++++++++++++
 tb/tb_cpu_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Instruction-sequencing FSM for the simple RISC CPU: fetch/decode/execute,
// LDR/STR with a mem_ready handshake and timeout, conditional branches, sticky error.
module cpu_controller #(
   parameter int MEM_TIMEOUT   = 15,
   parameter int CNT_W         = 4,
   parameter int ENABLE_BRANCH = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [2:0] cond,
   input  logic       Z,
   input  logic       N,
   input  logic       V,
   input  logic       mem_ready,
   output logic       w,
   output logic       halted,
   output logic       err,
   output logic [2:0] nsel,
   output logic [3:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       pc_sel,
   output logic       load_ir,
   output logic       addr_sel,
   output logic       load_addr,
   output logic [1:0] m_cmd
);
   typedef enum logic [4:0] {
      S_RESET, S_IF1, S_IF2, S_UPDATEPC, S_DECODE, S_MOVIMM, S_GETA, S_GETB,
      S_ALU, S_CMP, S_PASSB, S_WB, S_ADDR, S_LDADDR, S_MEMRD, S_LDRWB,
      S_STRGETB, S_STRPASS, S_MEMWR, S_BRANCH, S_HALT, S_ERROR
   } state_t;

   localparam int              TO_M1   = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);

   state_t           state, next;
   logic [CNT_W-1:0] cnt;
   logic             wait_st, timeout, ldst, taken, bad_cond;

   assign wait_st  = (state == S_IF1) || (state == S_MEMRD) || (state == S_MEMWR);
   assign timeout  = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (cnt == TO_LAST);
   assign ldst     = (opcode == 3'b011) || (opcode == 3'b100);
   assign bad_cond = (cond > 3'b100);

   always_comb begin
      case (cond)
         3'b000:  taken = 1'b1;
         3'b001:  taken = Z;
         3'b010:  taken = !Z;
         3'b011:  taken = N ^ V;
         3'b100:  taken = (N ^ V) | Z;
         default: taken = 1'b0;
      endcase
   end

   // Counter only runs while stalled in a wait state, so leaving and re-entering clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_RESET;
         cnt   <= '0;
      end else begin
         state <= next;
         cnt   <= (wait_st && !mem_ready) ? cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      next = state;
      w = 1'b0; halted = 1'b0; err = 1'b0; nsel = 3'b000; vsel = 4'b0000;
      write = 1'b0; loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
      asel = 1'b0; bsel = 1'b0; load_pc = 1'b0; reset_pc = 1'b0; pc_sel = 1'b0;
      load_ir = 1'b0; addr_sel = 1'b0; load_addr = 1'b0; m_cmd = 2'b00;
      case (state)
         S_RESET: begin
            reset_pc = 1'b1; load_pc = 1'b1; w = 1'b1; next = S_IF1;
         end
         S_IF1: begin
            w = 1'b1; addr_sel = 1'b1; m_cmd = 2'b01;
            if (timeout)        next = S_ERROR;
            else if (mem_ready) next = S_IF2;
         end
         S_IF2: begin
            w = 1'b1; addr_sel = 1'b1; m_cmd = 2'b01; load_ir = 1'b1; next = S_UPDATEPC;
         end
         S_UPDATEPC: begin
            w = 1'b1; load_pc = 1'b1; next = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               3'b110:  next = (op == 2'b10) ? S_MOVIMM : (op == 2'b00) ? S_GETB : S_ERROR;
               3'b101:  next = (op == 2'b11) ? S_GETB : S_GETA;
               3'b011,
               3'b100:  next = S_GETA;
               3'b111:  next = S_HALT;
               3'b001:  next = (ENABLE_BRANCH != 0) ? S_BRANCH : S_ERROR;
               default: next = S_ERROR;
            endcase
         end
         S_MOVIMM: begin
            write = 1'b1; vsel = 4'b0010; nsel = 3'b100; next = S_IF1;
         end
         S_GETA: begin
            loada = 1'b1; nsel = 3'b100; next = ldst ? S_ADDR : S_GETB;
         end
         S_GETB: begin
            loadb = 1'b1; nsel = 3'b001;
            if (opcode == 3'b101 && op == 2'b01)                    next = S_CMP;
            else if (opcode == 3'b101 && (op == 2'b00 || op == 2'b10)) next = S_ALU;
            else                                                      next = S_PASSB;
         end
         S_ALU:   begin loadc = 1'b1; next = S_WB; end
         S_CMP:   begin loads = 1'b1; next = S_IF1; end
         S_PASSB: begin asel = 1'b1; loadc = 1'b1; next = S_WB; end
         S_WB: begin
            write = 1'b1; vsel = 4'b0001; nsel = 3'b010; next = S_IF1;
         end
         S_ADDR:   begin bsel = 1'b1; loadc = 1'b1; next = S_LDADDR; end
         S_LDADDR: begin
            load_addr = 1'b1; next = (opcode == 3'b011) ? S_MEMRD : S_STRGETB;
         end
         S_MEMRD: begin
            m_cmd = 2'b01;
            if (timeout)        next = S_ERROR;
            else if (mem_ready) next = S_LDRWB;
         end
         S_LDRWB: begin
            m_cmd = 2'b01; write = 1'b1; vsel = 4'b1000; nsel = 3'b010; next = S_IF1;
         end
         S_STRGETB: begin loadb = 1'b1; nsel = 3'b010; next = S_STRPASS; end
         S_STRPASS: begin asel = 1'b1; loadc = 1'b1; next = S_MEMWR; end
         S_MEMWR: begin
            m_cmd = 2'b10;
            if (timeout)        next = S_ERROR;
            else if (mem_ready) next = S_IF1;
         end
         // Only state whose outputs look at inputs: the PC load follows the flags.
         S_BRANCH: begin
            if (bad_cond) next = S_ERROR;
            else begin
               load_pc = taken; pc_sel = taken; next = S_IF1;
            end
         end
         S_HALT:  halted = 1'b1;
         S_ERROR: err = 1'b1;
         default: next = S_ERROR;
      endcase
   end
endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle vector table plus hand sequences for
// memory timeout, branch disable, sticky error, halt and asynchronous reset.
module tb_cpu_controller;
   logic       clk, rst;
   logic [2:0] opcode, cond;
   logic [1:0] op;
   logic       zf, nf, vf, mem_ready;
   int         errors = 0, checks = 0;

   // Packed view: {w,halted,err,nsel,vsel,write,loada,loadb,loadc,loads,asel,bsel,
   //               load_pc,reset_pc,pc_sel,load_ir,addr_sel,load_addr,m_cmd}
   wire [24:0] o [3];

   localparam logic [24:0] W   = 25'd1 << 24, HLT = 25'd1 << 23, ERR = 25'd1 << 22;
   localparam logic [24:0] NSN = 25'd4 << 19, NSD = 25'd2 << 19, NSM = 25'd1 << 19;
   localparam logic [24:0] VSC = 25'd1 << 15, VSI = 25'd2 << 15, VSM = 25'd8 << 15;
   localparam logic [24:0] WR  = 25'd1 << 14, LA = 25'd1 << 13, LB = 25'd1 << 12;
   localparam logic [24:0] LC  = 25'd1 << 11, LS = 25'd1 << 10, AS = 25'd1 << 9;
   localparam logic [24:0] BS  = 25'd1 << 8, LPC = 25'd1 << 7, RPC = 25'd1 << 6;
   localparam logic [24:0] PCS = 25'd1 << 5, LIR = 25'd1 << 4, ASL = 25'd1 << 3;
   localparam logic [24:0] LAD = 25'd1 << 2, MRD = 25'd1, MWR = 25'd2;

   localparam logic [24:0] S_RST = W | RPC | LPC, S_IF1 = W | ASL | MRD;
   localparam logic [24:0] S_IF2 = W | ASL | MRD | LIR, S_UPC = W | LPC, S_DEC = '0;
   localparam logic [24:0] S_MOVI = WR | VSI | NSN, S_GETA = LA | NSN, S_GETB = LB | NSM;
   localparam logic [24:0] S_ALU = LC, S_CMP = LS, S_PASS = AS | LC, S_WB = WR | VSC | NSD;
   localparam logic [24:0] S_ADDR = BS | LC, S_LDA = LAD, S_MRD = MRD;
   localparam logic [24:0] S_LWB = MRD | WR | VSM | NSD, S_SGB = LB | NSD, S_SPS = AS | LC;
   localparam logic [24:0] S_MWR = MWR, S_BRT = LPC | PCS, S_BRN = '0;
   localparam logic [24:0] S_HLT = HLT, S_ERR = ERR;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : gen_dut
         cpu_controller #(
            .MEM_TIMEOUT  (g == 2 ? 0 : 15),
            .CNT_W        (4),
            .ENABLE_BRANCH(g == 1 ? 0 : 1)
         ) dut (
            .clk(clk), .reset(rst), .opcode(opcode), .op(op), .cond(cond),
            .Z(zf), .N(nf), .V(vf), .mem_ready(mem_ready),
            .w(o[g][24]), .halted(o[g][23]), .err(o[g][22]), .nsel(o[g][21:19]),
            .vsel(o[g][18:15]), .write(o[g][14]), .loada(o[g][13]), .loadb(o[g][12]),
            .loadc(o[g][11]), .loads(o[g][10]), .asel(o[g][9]), .bsel(o[g][8]),
            .load_pc(o[g][7]), .reset_pc(o[g][6]), .pc_sel(o[g][5]), .load_ir(o[g][4]),
            .addr_sel(o[g][3]), .load_addr(o[g][2]), .m_cmd(o[g][1:0])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  opc;
      logic [1:0]  op;
      logic [2:0]  cond;
      logic [2:0]  znv;
      logic        rdy;
      logic [24:0] exp;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic [2:0] a, input logic [1:0] b, input logic [2:0] c,
                      input logic [2:0] f, input logic r, input logic [24:0] e);
      vec_t v;
      v.opc = a; v.op = b; v.cond = c; v.znv = f; v.rdy = r; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic fetch(input logic [2:0] a, input logic [1:0] b, input logic [2:0] c,
                        input logic [2:0] f);
      add(a, b, c, f, 1'b1, S_IF1); add(a, b, c, f, 1'b1, S_IF2);
      add(a, b, c, f, 1'b1, S_UPC); add(a, b, c, f, 1'b1, S_DEC);
   endtask

   task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] a, input logic [1:0] b, input logic [2:0] c,
                        input logic [2:0] f, input logic r);
      opcode = a; op = b; cond = c; {zf, nf, vf} = f; mem_ready = r;
   endtask

   // Leaves the bench at a falling edge with reset released and all DUTs in RESET.
   task automatic do_reset(input string name);
      rst = 1'b1;
      #1 chk(name, o[0], S_RST);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(3'b000, 2'b00, 3'b000, 3'b000, 1'b1);
      // MOVIMM
      add(3'b110, 2'b10, 0, 0, 1, S_RST);
      fetch(3'b110, 2'b10, 0, 0); add(3'b110, 2'b10, 0, 0, 1, S_MOVI);
      // ADD, CMP, MVN, MOV reg, AND
      fetch(3'b101, 2'b00, 0, 0);
      add(3'b101, 2'b00, 0, 0, 1, S_GETA); add(3'b101, 2'b00, 0, 0, 1, S_GETB);
      add(3'b101, 2'b00, 0, 0, 1, S_ALU);  add(3'b101, 2'b00, 0, 0, 1, S_WB);
      fetch(3'b101, 2'b01, 0, 0);
      add(3'b101, 2'b01, 0, 0, 1, S_GETA); add(3'b101, 2'b01, 0, 0, 1, S_GETB);
      add(3'b101, 2'b01, 0, 0, 1, S_CMP);
      fetch(3'b101, 2'b11, 0, 0);
      add(3'b101, 2'b11, 0, 0, 1, S_GETB); add(3'b101, 2'b11, 0, 0, 1, S_PASS);
      add(3'b101, 2'b11, 0, 0, 1, S_WB);
      fetch(3'b110, 2'b00, 0, 0);
      add(3'b110, 2'b00, 0, 0, 1, S_GETB); add(3'b110, 2'b00, 0, 0, 1, S_PASS);
      add(3'b110, 2'b00, 0, 0, 1, S_WB);
      fetch(3'b101, 2'b10, 0, 0);
      add(3'b101, 2'b10, 0, 0, 1, S_GETA); add(3'b101, 2'b10, 0, 0, 1, S_GETB);
      add(3'b101, 2'b10, 0, 0, 1, S_ALU);  add(3'b101, 2'b10, 0, 0, 1, S_WB);
      // LDR with 3 wait cycles in MEMRD
      fetch(3'b011, 2'b00, 0, 0);
      add(3'b011, 0, 0, 0, 1, S_GETA); add(3'b011, 0, 0, 0, 1, S_ADDR);
      add(3'b011, 0, 0, 0, 1, S_LDA);
      add(3'b011, 0, 0, 0, 0, S_MRD); add(3'b011, 0, 0, 0, 0, S_MRD);
      add(3'b011, 0, 0, 0, 0, S_MRD); add(3'b011, 0, 0, 0, 1, S_MRD);
      add(3'b011, 0, 0, 0, 1, S_LWB);
      // STR with one wait cycle in MEMWR
      fetch(3'b100, 2'b00, 0, 0);
      add(3'b100, 0, 0, 0, 1, S_GETA); add(3'b100, 0, 0, 0, 1, S_ADDR);
      add(3'b100, 0, 0, 0, 1, S_LDA);  add(3'b100, 0, 0, 0, 1, S_SGB);
      add(3'b100, 0, 0, 0, 1, S_SPS);  add(3'b100, 0, 0, 0, 0, S_MWR);
      add(3'b100, 0, 0, 0, 1, S_MWR);
      // BEQ Z=1 after two fetch wait cycles, then more branch conditions
      add(3'b001, 0, 3'b001, 3'b100, 0, S_IF1); add(3'b001, 0, 3'b001, 3'b100, 0, S_IF1);
      fetch(3'b001, 0, 3'b001, 3'b100); add(3'b001, 0, 3'b001, 3'b100, 1, S_BRT);
      fetch(3'b001, 0, 3'b001, 3'b000); add(3'b001, 0, 3'b001, 3'b000, 1, S_BRN);
      fetch(3'b001, 0, 3'b011, 3'b010); add(3'b001, 0, 3'b011, 3'b010, 1, S_BRT);
      fetch(3'b001, 0, 3'b100, 3'b000); add(3'b001, 0, 3'b100, 3'b000, 1, S_BRN);
      fetch(3'b001, 0, 3'b100, 3'b100); add(3'b001, 0, 3'b100, 3'b100, 1, S_BRT);
      fetch(3'b001, 0, 3'b010, 3'b000); add(3'b001, 0, 3'b010, 3'b000, 1, S_BRT);
      add(3'b000, 0, 0, 0, 1, S_IF1);

      @(negedge clk);
      do_reset("reset_state");
      foreach (vecs[i]) begin
         drive(vecs[i].opc, vecs[i].op, vecs[i].cond, vecs[i].znv, vecs[i].rdy);
         #1 chk($sformatf("vec%0d", i), o[0], vecs[i].exp);
         @(posedge clk);
         @(negedge clk);
      end

      // Fetch timeout: exactly 15 IF1 cycles then ERROR; MEM_TIMEOUT=0 keeps waiting.
      do_reset("reset_to1");
      drive(3'b000, 0, 0, 0, 1'b0);
      step();
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("to_if1_%0d", i), o[0], S_IF1);
         step();
      end
      chk("to_error", o[0], S_ERR);
      for (int i = 0; i < 10; i++) step();
      chk("to_error_sticky", o[0], S_ERR);
      chk("notimeout_waiting", o[2], S_IF1);

      // Ready on the 15th cycle wins over the timeout.
      do_reset("reset_to2");
      drive(3'b000, 0, 0, 0, 1'b0);
      step();
      for (int i = 0; i < 14; i++) step();
      mem_ready = 1'b1;
      #1 chk("to_last_if1", o[0], S_IF1);
      step();
      chk("to_ready_wins", o[0], S_IF2);

      // Branch disabled: opcode 001 is illegal; enabled DUT takes the always-branch.
      do_reset("reset_nb");
      drive(3'b001, 0, 3'b000, 0, 1'b1);
      for (int i = 0; i < 5; i++) step();
      chk("nb_error", o[1], S_ERR);
      chk("br_always", o[0], S_BRT);
      for (int i = 0; i < 3; i++) step();
      chk("nb_error_sticky", o[1], S_ERR);

      // Bad branch condition: sticky error until reset.
      do_reset("reset_bc");
      drive(3'b001, 0, 3'b110, 3'b111, 1'b1);
      for (int i = 0; i < 5; i++) step();
      chk("badcond_nopc", o[0], S_BRN);
      step();
      for (int i = 0; i < 6; i++) step();
      chk("badcond_err_held", o[0], S_ERR);
      do_reset("reset_clears_err");
      step();
      chk("err_cleared_if1", o[0], S_IF1);

      // HALT holds for 20+ cycles.
      do_reset("reset_halt");
      drive(3'b111, 0, 0, 0, 1'b1);
      for (int i = 0; i < 5; i++) step();
      for (int i = 0; i < 22; i++) begin
         if (i % 7 == 0) chk($sformatf("halt_%0d", i), o[0], S_HLT);
         step();
      end
      chk("halt_end", o[0], S_HLT);

      // Asynchronous reset in the middle of a MEMRD wait.
      do_reset("reset_ar");
      drive(3'b011, 0, 0, 0, 1'b1);
      for (int i = 0; i < 8; i++) step();
      chk("ar_memrd", o[0], S_MRD);
      mem_ready = 1'b0;
      step(); step();
      chk("ar_memrd_wait", o[0], S_MRD);
      #2 rst = 1'b1;
      #1 chk("ar_immediate", o[0], S_RST);
      chk("ar_immediate_nt", o[2], S_RST);
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b1;
      #1 chk("ar_hold", o[0], S_RST);
      step();
      chk("ar_if1", o[0], S_IF1);
      step();
      chk("ar_if2", o[0], S_IF2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
